// File: rtl/jpeg_block_rasterizer.sv
// jpeg_block_rasterizer: turns 8x8 RGB blocks arriving in 4:2:0 MCU order into
// a cropped raster pixel stream. Two 16-row MCU-row banks ping-pong: one is
// filled by the block writer while the other is scanned by the pixel reader.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload steady
// until the transfer. ready may depend on state and on the opposite port's
// ready, but never on the same port's valid.
module jpeg_block_rasterizer #(
   parameter int MAX_WIDTH = 256,
   parameter int DIM_BITS  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIM_BITS-1:0]   img_width,
   input  logic [DIM_BITS-1:0]   img_height,
   input  logic [7:0][7:0][7:0]  blk_r,
   input  logic [7:0][7:0][7:0]  blk_g,
   input  logic [7:0][7:0][7:0]  blk_b,
   input  logic                  blk_valid,
   output logic                  blk_ready,
   output logic [7:0]            pix_r,
   output logic [7:0]            pix_g,
   output logic [7:0]            pix_b,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_eol,
   output logic                  pix_eof
);

   localparam int CW = $clog2(MAX_WIDTH);

   // Pixel storage: [bank][row within MCU row][column]
   logic [23:0] mem [2][16][MAX_WIDTH];

   // Frame dimensions, latched at frame start
   logic                need_start;
   logic [DIM_BITS-1:0] w_lat;
   logic [DIM_BITS-1:0] mcus_q;
   logic [DIM_BITS-1:0] mcu_rows_q;
   logic [3:0]          h_low;

   // Writer state
   logic [7:0][7:0][7:0] hold_r, hold_g, hold_b;
   logic                 busy;
   logic [2:0]           wr_row;
   logic [1:0]           k;
   logic [DIM_BITS-1:0]  m;
   logic [DIM_BITS-1:0]  wrow;
   logic                 wdone;

   // Bank state: wsel is the write bank, the other one is the read bank
   logic wsel, full_w, full_r, wlast, rlast;

   // Reader state: address of the next pixel to load into the output register
   logic [3:0]    rd_row;
   logic [CW-1:0] rd_col;
   logic          iss_done;
   logic          out_lob;

   // Combinational helpers
   logic          out_free, last_cons, eof_cons, swap, ld;
   logic          ld_bank, ld_last, ld_eol, ld_rend;
   logic [3:0]    ld_row, r_m1;
   logic [CW-1:0] ld_col, wcol;
   logic [23:0]   ld_pix;
   logic          mcu_done, frame_last_row;

   // Bank swap / reader load decisions and writer handshake
   always_comb begin
      out_free       = !pix_valid || pix_ready;
      last_cons      = pix_valid && pix_ready && out_lob;
      eof_cons       = pix_valid && pix_ready && pix_eof;
      // A full write bank moves to the read side as soon as the read side is
      // free, including the cycle its last pixel leaves, so banks chain with
      // no bubble.
      swap           = full_w && (!full_r || last_cons);
      ld             = (full_r && !iss_done && out_free) || swap;
      ld_bank        = swap ? wsel : ~wsel;
      ld_row         = swap ? 4'd0 : rd_row;
      ld_col         = swap ? '0 : rd_col;
      ld_last        = swap ? wlast : rlast;
      // Rows in the final MCU row: h mod 16, or 16 when h is a multiple of 16
      r_m1           = ld_last ? (h_low - 4'd1) : 4'd15;
      ld_eol         = DIM_BITS'(ld_col) == (w_lat - DIM_BITS'(1));
      ld_rend        = ld_row == r_m1;
      ld_pix         = mem[ld_bank][ld_row][ld_col];
      wcol           = CW'({m, k[0], 3'b000});
      frame_last_row = wrow == (mcu_rows_q - DIM_BITS'(1));
      mcu_done       = busy && (wr_row == 3'd7) && (k == 2'd3) &&
                       ((m + DIM_BITS'(1)) == mcus_q);
      blk_ready      = !rst && !busy && !wdone && (!full_w || swap);
   end

   // Frame start latching and block writer counters
   always_ff @(posedge clk) begin
      if (rst) begin
         need_start <= 1'b1;
         w_lat      <= '0;
         mcus_q     <= '0;
         mcu_rows_q <= '0;
         h_low      <= '0;
         hold_r     <= '0;
         hold_g     <= '0;
         hold_b     <= '0;
         busy       <= 1'b0;
         wr_row     <= '0;
         k          <= '0;
         m          <= '0;
         wrow       <= '0;
         wdone      <= 1'b0;
      end else begin
         need_start <= eof_cons;
         if (need_start) begin
            w_lat      <= img_width;
            h_low      <= img_height[3:0];
            mcus_q     <= DIM_BITS'(img_width[DIM_BITS-1:4]) +
                          DIM_BITS'(img_width[3:0] != 4'd0);
            mcu_rows_q <= DIM_BITS'(img_height[DIM_BITS-1:4]) +
                          DIM_BITS'(img_height[3:0] != 4'd0);
            wrow       <= '0;
            m          <= '0;
            k          <= '0;
            wdone      <= 1'b0;
         end
         if (blk_valid && blk_ready) begin
            hold_r <= blk_r;
            hold_g <= blk_g;
            hold_b <= blk_b;
            busy   <= 1'b1;
            wr_row <= '0;
         end else if (busy) begin
            wr_row <= wr_row + 3'd1;
            if (wr_row == 3'd7) begin
               busy <= 1'b0;
               k    <= k + 2'd1;
               if (k == 2'd3) begin
                  if (mcu_done) begin
                     m <= '0;
                     if (frame_last_row) begin
                        wrow  <= '0;
                        wdone <= 1'b1;
                     end else begin
                        wrow <= wrow + DIM_BITS'(1);
                     end
                  end else begin
                     m <= m + DIM_BITS'(1);
                  end
               end
            end
         end
      end
   end

   // Copy one held block row (8 pixels) into the write bank per busy cycle
   always_ff @(posedge clk) begin
      if (busy) begin
         for (int i = 0; i < 8; i++) begin
            mem[wsel][{k[1], wr_row}][wcol + CW'(i)] <=
               {hold_r[wr_row][3'(i)], hold_g[wr_row][3'(i)], hold_b[wr_row][3'(i)]};
         end
      end
   end

   // Bank ownership: mark full after the last MCU of a row, swap, mark empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wsel   <= 1'b0;
         full_w <= 1'b0;
         full_r <= 1'b0;
         wlast  <= 1'b0;
         rlast  <= 1'b0;
      end else begin
         if (swap) begin
            wsel   <= ~wsel;
            full_r <= 1'b1;
            full_w <= 1'b0;
            rlast  <= wlast;
         end else if (last_cons) begin
            full_r <= 1'b0;
         end
         if (mcu_done) begin
            full_w <= 1'b1;
            wlast  <= frame_last_row;
         end
      end
   end

   // Pixel reader: raster scan of the read bank into the output register
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_r     <= '0;
         pix_g     <= '0;
         pix_b     <= '0;
         pix_valid <= 1'b0;
         pix_eol   <= 1'b0;
         pix_eof   <= 1'b0;
         out_lob   <= 1'b0;
         rd_row    <= '0;
         rd_col    <= '0;
         iss_done  <= 1'b0;
      end else if (ld) begin
         {pix_r, pix_g, pix_b} <= ld_pix;
         pix_valid <= 1'b1;
         pix_eol   <= ld_eol;
         out_lob   <= ld_eol && ld_rend;
         pix_eof   <= ld_eol && ld_rend && ld_last;
         if (ld_eol) begin
            rd_col <= '0;
            if (ld_rend) begin
               rd_row   <= '0;
               iss_done <= 1'b1;
            end else begin
               rd_row   <= ld_row + 4'd1;
               iss_done <= 1'b0;
            end
         end else begin
            rd_col   <= ld_col + CW'(1);
            rd_row   <= ld_row;
            iss_done <= 1'b0;
         end
      end else if (pix_valid && pix_ready) begin
         pix_valid <= 1'b0;
         pix_eol   <= 1'b0;
         pix_eof   <= 1'b0;
         out_lob   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jpeg_block_rasterizer.sv
// Bench for jpeg_block_rasterizer: images live on a 64x64 canvas; blocks are
// cut from it in MCU order and the expected output is the cropped raster.
module tb_jpeg_block_rasterizer;

  typedef struct packed {
    logic [7:0][7:0][7:0] r;
    logic [7:0][7:0][7:0] g;
    logic [7:0][7:0][7:0] b;
  } blk_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [15:0]          img_width = 16'd16;
  logic [15:0]          img_height = 16'd16;
  logic [7:0][7:0][7:0] blk_r = '0;
  logic [7:0][7:0][7:0] blk_g = '0;
  logic [7:0][7:0][7:0] blk_b = '0;
  logic                 blk_valid = 1'b0;
  logic                 blk_ready;
  logic [7:0]           pix_r, pix_g, pix_b;
  logic                 pix_valid;
  logic                 pix_ready = 1'b0;
  logic                 pix_eol, pix_eof;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_valid = -1;
  int acc_q[$];
  blk_t blk_q[$];
  logic [25:0] exp_q[$];
  logic [23:0] img [64][64];

  jpeg_block_rasterizer #(.MAX_WIDTH(256), .DIM_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .img_width(img_width), .img_height(img_height),
    .blk_r(blk_r), .blk_g(blk_g), .blk_b(blk_b),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // canvas patterns: 0 = per-block constant 10/20/30/40, 1 = coordinates, 2 = random
  task automatic fill(input int mode);
    int v;
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        case (mode)
          0: begin
            v = 10 * (1 + 2 * ((y % 16) / 8) + ((x % 16) / 8));
            img[y][x] = {8'(v), 8'(v + 1), 8'(v + 2)};
          end
          1: img[y][x] = {8'(y), 8'(x), 8'(y * 3 + x * 5)};
          default: img[y][x] = 24'($urandom);
        endcase
      end
    end
  endtask

  // reference: blocks in MCU order, expected pixels {eof, eol, rgb} in raster order
  task automatic queue_frame(input int w, input int h);
    blk_t bk;
    logic [23:0] p;
    for (int mr = 0; mr < (h + 15) / 16; mr++) begin
      for (int mc = 0; mc < (w + 15) / 16; mc++) begin
        for (int kk = 0; kk < 4; kk++) begin
          for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
              p = img[16 * mr + 8 * (kk / 2) + r][16 * mc + 8 * (kk % 2) + c];
              bk.r[r][c] = p[23:16];
              bk.g[r][c] = p[15:8];
              bk.b[r][c] = p[7:0];
            end
          end
          blk_q.push_back(bk);
        end
      end
    end
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back({(y == h - 1) && (x == w - 1), (x == w - 1), img[y][x]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    blk_valid = 1'b0;
    pix_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_blk_ready", 32'(blk_ready), 32'd0);
    check("rst_outputs", 32'({pix_valid, pix_eol, pix_eof, pix_r, pix_g, pix_b}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_exit_blk_ready", 32'(blk_ready), 32'd1);
  endtask

  // driver: call at the #2 point of a cycle
  task automatic drive_blocks(input int n);
    blk_t bk;
    int guard;
    for (int i = 0; i < n; i++) begin
      bk = blk_q.pop_front();
      blk_r = bk.r;
      blk_g = bk.g;
      blk_b = bk.b;
      blk_valid = 1'b1;
      guard = 0;
      while (!blk_ready && guard < 5000) begin
        @(posedge clk); #2;
        guard++;
      end
      if (!blk_ready) check("blk_accept_timeout", 32'(blk_ready), 32'd1);
      acc_q.push_back(cyc);
      @(posedge clk); #2;
      blk_valid = 1'b0;
    end
  endtask

  // receiver: checks every consumed pixel and hold stability while stalled
  task automatic receive(input int n, input bit rnd);
    int got, guard;
    logic [26:0] cur, prev;
    bit stall;
    got = 0; guard = 0; stall = 1'b0; prev = '0;
    while (got < n && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      cur = {pix_valid, pix_eof, pix_eol, pix_r, pix_g, pix_b};
      if (stall) check("hold_stable", 32'(cur), 32'(prev));
      if (pix_valid && first_valid < 0) first_valid = cyc;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        check("pixel", 32'(cur[25:0]), 32'(exp_q.pop_front()));
        got++;
      end
      stall = pix_valid && !pix_ready;
      prev = cur;
    end
    check("rx_count", 32'(got), 32'(n));
  endtask

  task automatic expect_idle(input string tag, input int n);
    int seen;
    seen = 0;
    pix_ready = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      if (pix_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    // 1: 16x16 single MCU, constant blocks, timing of accept and first pixel
    img_width = 16; img_height = 16;
    do_reset();
    fill(0);
    queue_frame(16, 16);
    acc_q.delete();
    first_valid = -1;
    #1;
    fork
      drive_blocks(4);
      receive(256, 1'b0);
    join
    check("accept_gap01", 32'(acc_q[1] - acc_q[0]), 32'd9);
    check("accept_gap23", 32'(acc_q[3] - acc_q[2]), 32'd9);
    check("first_pix_latency", 32'(first_valid - acc_q[3]), 32'd10);
    expect_idle("idle_16x16", 20);

    // 2: 20x10, coordinate pattern, padding cropped
    img_width = 20; img_height = 10;
    do_reset();
    fill(1);
    queue_frame(20, 10);
    #1;
    fork
      drive_blocks(8);
      receive(200, 1'b0);
    join
    expect_idle("idle_20x10", 30);

    // 3: 32x32 with the sink stalled: both banks fill, writer held off
    img_width = 32; img_height = 32;
    do_reset();
    fill(2);
    queue_frame(32, 32);
    #1;
    drive_blocks(16);
    begin
      int rdy_seen;
      rdy_seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (blk_ready) rdy_seen++;
      end
      check("stall_blk_ready_low", 32'(rdy_seen), 32'd0);
    end
    check("stall_first_pixel_held",
          32'({pix_valid, pix_eof, pix_eol, pix_r, pix_g, pix_b}), 32'({1'b1, exp_q[0]}));
    receive(1024, 1'b0);
    expect_idle("idle_32x32", 20);

    // 4: 48x32 random data with random backpressure
    img_width = 48; img_height = 32;
    do_reset();
    fill(2);
    queue_frame(48, 32);
    #1;
    fork
      drive_blocks(24);
      receive(1536, 1'b1);
    join
    expect_idle("idle_48x32", 20);

    // 5: reset mid-frame after 5 blocks, then a fresh 16x16 frame
    img_width = 16; img_height = 32;
    do_reset();
    fill(2);
    img[0][0] = 24'hABCDEF;
    queue_frame(16, 32);
    #1;
    drive_blocks(5);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(pix_valid), 32'd1);
    check("pre_rst_pixel", 32'({pix_r, pix_g, pix_b}), 32'h00ABCDEF);
    blk_q.delete();
    exp_q.delete();
    img_width = 16; img_height = 16;
    do_reset();
    fill(2);
    queue_frame(16, 16);
    #1;
    fork
      drive_blocks(4);
      receive(256, 1'b0);
    join
    expect_idle("idle_after_rst", 20);

    // 6: back-to-back frames, dims changed while the first frame is in flight
    img_width = 16; img_height = 16;
    do_reset();
    fill(2);
    queue_frame(16, 16);
    fill(1);
    queue_frame(32, 16);
    #1;
    fork
      begin
        drive_blocks(4);
        img_width = 32;
        img_height = 16;
        drive_blocks(8);
      end
      receive(256 + 512, 1'b0);
    join
    expect_idle("idle_b2b", 20);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
